// File: rtl/imem_loader.sv
// imem_loader: write-side loader for the instruction memory.
//
// Accepts a framed byte stream over a valid/ready handshake, assembles bytes
// into DATA_W-bit big-endian words and writes them to imem at consecutive word
// addresses starting from 0. While a frame is in progress the core is held in
// reset. At the end of the frame done_o is set, and err_o is set if the
// trailing XOR checksum does not match.
//
// Frame: MAGIC, CNT_HI, CNT_LO, N*(DATA_W/8) payload bytes, CSUM.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   rx_data_i     incoming byte
//   rx_valid_i    rx_data_i valid
//   rx_ready_o    loader can accept a byte (transfer on valid & ready)
//   we_o          imem write strobe, one cycle per word
//   waddr_o       imem write word address
//   wdata_o       imem write data
//   cpu_hold_o    holds the core in reset while loading
//   busy_o        frame in progress
//   done_o        sticky, last frame completed
//   err_o         sticky, last frame had a checksum mismatch
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Bytes - 1);

  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : gen_bad_width
    $error("imem_loader: DATA_W must be a non-zero multiple of 8");
  end

  typedef enum logic [2:0] {
    StIdle,
    StCntH,
    StCntL,
    StLoad,
    StWrite,
    StCsum,
    StDone
  } state_e;

  state_e            state_q;
  logic [7:0]        cnt_hi_q;
  logic [15:0]       words_left_q;
  logic [IdxW-1:0]   byte_idx_q;
  logic [DATA_W-1:0] word_q;
  logic [7:0]        csum_q;

  logic              accept;
  logic [15:0]       count;
  logic [DATA_W-1:0] word_next;

  assign accept    = rx_valid_i & rx_ready_o;
  assign count     = {cnt_hi_q, rx_data_i};
  // Big-endian assembly: earlier bytes shift towards the MSB.
  assign word_next = DATA_W'({word_q, rx_data_i});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_hi_q     <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      rx_ready_o   <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      cpu_hold_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      // Ready is dropped only for the WRITE cycle; the strobe is one cycle wide.
      rx_ready_o <= 1'b1;
      we_o       <= 1'b0;
      unique case (state_q)
        // DONE behaves like IDLE for an incoming byte so no byte slot is lost.
        StIdle, StDone: begin
          state_q <= StIdle;
          if (accept && rx_data_i == MAGIC) begin
            state_q    <= StCntH;
            busy_o     <= 1'b1;
            cpu_hold_o <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
          end
        end
        StCntH: begin
          if (accept) begin
            cnt_hi_q <= rx_data_i;
            state_q  <= StCntL;
          end
        end
        StCntL: begin
          if (accept) begin
            words_left_q <= count;
            waddr_o      <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
            state_q      <= (count == 16'd0) ? StCsum : StLoad;
          end
        end
        StLoad: begin
          if (accept) begin
            word_q <= word_next;
            csum_q <= csum_q ^ rx_data_i;
            if (byte_idx_q == LastIdx) begin
              byte_idx_q <= '0;
              wdata_o    <= word_next;
              we_o       <= 1'b1;
              rx_ready_o <= 1'b0;
              state_q    <= StWrite;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
        end
        StWrite: begin
          // Address advances after the strobe cycle; wraps naturally.
          waddr_o      <= waddr_o + 1'b1;
          words_left_q <= words_left_q - 16'd1;
          state_q      <= (words_left_q == 16'd1) ? StCsum : StLoad;
        end
        StCsum: begin
          if (accept) begin
            err_o      <= (rx_data_i != csum_q);
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            cpu_hold_o <= 1'b0;
            state_q    <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (DATA_W=32, ADDR_W=8). Expected imem writes are
// queued as frames are driven and checked as we_o pulses appear.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready_o;
  logic        we_o;
  logic [7:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  imem_loader #(
    .ADDR_W(8),
    .DATA_W(32),
    .MAGIC (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready_o),
    .we_o      (we_o),
    .waddr_o   (waddr_o),
    .wdata_o   (wdata_o),
    .cpu_hold_o(cpu_hold_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  ready_low = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!rx_ready_o) ready_low++;
      if (we_o) begin
        if (sb.size() == 0) begin
          check("spurious_we", 64'd1, 64'd0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("waddr", {56'd0, waddr_o}, {56'd0, e.addr});
          check("wdata", {32'd0, wdata_o}, {32'd0, e.data});
        end
      end
    end
  end

  // Present one byte and return on the posedge that accepts it.
  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int guard = 0;
    bit go = 1'b0;
    while (!go) begin
      @(negedge clk);
      if (gappy && $urandom_range(1, 0) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        if (rx_ready_o) go = 1'b1;
      end
      guard++;
      if (guard > 2000) begin
        check("accept_timeout", 64'd0, 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "byte never accepted");
      end
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [31:0] words[$], input bit bad, input bit gappy,
                            input string tag);
    logic [7:0]  cs = 8'h00;
    logic [31:0] w;
    logic [15:0] n;
    n = 16'(words.size());
    send_byte(8'hA5, gappy);
    #1;
    check({tag, "_start_flags"}, {60'd0, cpu_hold_o, busy_o, done_o, err_o}, 64'b1100);
    ready_low = 0;
    send_byte(n[15:8], gappy);
    send_byte(n[7:0], gappy);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      sb.push_back('{addr: 8'(i), data: w});
      for (int b = 0; b < 4; b++) begin
        cs ^= w[31-8*b -: 8];
        send_byte(w[31-8*b -: 8], gappy);
      end
    end
    send_byte(cs ^ {7'd0, bad}, gappy);
    #1;
    check({tag, "_end_flags"}, {60'd0, cpu_hold_o, busy_o, done_o, err_o},
          {60'd0, 3'b001, bad});
    check({tag, "_writes_left"}, 64'(sb.size()), 64'd0);
    check({tag, "_ready_low"}, 64'(ready_low), 64'(n));
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w[$];
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #3;
    check("reset_outputs",
          {18'd0, rx_ready_o, we_o, waddr_o, wdata_o, cpu_hold_o, busy_o, done_o, err_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {63'd0, rx_ready_o}, 64'd1);

    // Basic two-word frame.
    w = '{32'h11223344, 32'hDEADBEEF};
    send_frame(w, 1'b0, 1'b0, "basic");
    repeat (3) @(posedge clk);
    #1;
    check("done_sticky", {61'd0, busy_o, done_o, err_o}, 64'b010);

    // Corrupted checksum: writes still happen, err raised.
    send_frame(w, 1'b1, 1'b0, "badcsum");

    // Garbage before the frame is ignored; empty frame.
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    #1;
    check("garbage_idle", {62'd0, busy_o, cpu_hold_o}, 64'd0);
    w = {};
    send_frame(w, 1'b0, 1'b0, "empty");

    // 257 words: address wraps back to 0 for the last one.
    w = {};
    for (int i = 0; i < 257; i++) w.push_back(32'(i));
    send_frame(w, 1'b0, 1'b0, "wrap");

    // Random valid gaps.
    w = '{32'h11223344, 32'hDEADBEEF};
    send_frame(w, 1'b0, 1'b1, "gappy");

    // Asynchronous reset mid-payload.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1;
    check("async_reset",
          {18'd0, rx_ready_o, we_o, waddr_o, wdata_o, cpu_hold_o, busy_o, done_o, err_o}, 64'd0);
    repeat (2) @(negedge clk);
    check("reset_held", {60'd0, we_o, busy_o, cpu_hold_o, rx_ready_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst2", {63'd0, rx_ready_o}, 64'd1);
    w = '{32'hCAFEBABE, 32'h01020304};
    send_frame(w, 1'b0, 1'b0, "post_reset");

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 64'd0, 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory. It accepts a byte stream from the host link (UART RX or debug bridge) through a valid/ready handshake.
- It assembles the bytes into IMEM_WIDTH-bit instruction words and drives the imem write port with an auto-incrementing address.
- It holds the core in reset while a program image is loading, then reports done or error.

Parameters:
- ADDR_W, IMEM_DEPTH (from wi23_defs): imem word-address width.
- DATA_W, IMEM_WIDTH (from wi23_defs): instruction word width. Must be a multiple of 8.
- MAGIC, 8'hA5: frame start byte.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data_i  in  8  incoming byte.
- rx_valid_i  in  1  rx_data_i valid.
- rx_ready_o  out  1  loader can accept a byte; a transfer occurs when rx_valid_i and rx_ready_o are both high at posedge.
- we_o  out  1  imem write strobe, one cycle per word.
- waddr_o  out  ADDR_W  imem write word address.
- wdata_o  out  DATA_W  imem write data.
- cpu_hold_o  out  1  holds the core in reset while loading.
- busy_o  out  1  a frame is in progress.
- done_o  out  1  sticky; last frame completed.
- err_o  out  1  sticky; last frame had a checksum mismatch.

Behaviour:
- Reset values: rx_ready_o=0, we_o=0, waddr_o=0, wdata_o=0, cpu_hold_o=0, busy_o=0, done_o=0, err_o=0, state=IDLE.
  - rx_ready_o goes high the first cycle after rst_n deasserts.
- Frame format, in order:
  - MAGIC
  - CNT_HI, CNT_LO: 16-bit word count N, big-endian
  - N*(DATA_W/8) payload bytes; each word is big-endian (first byte goes to wdata[DATA_W-1:DATA_W-8])
  - CSUM: XOR of all payload bytes; 8'h00 when N=0
- All outputs are registered. Every state below advances only on an accepted byte, except WRITE.
- States and transitions:
  - IDLE: rx_ready_o=1.
    - Accepted byte == MAGIC: go to CNT_H, set busy_o=1 and cpu_hold_o=1, clear done_o and err_o.
    - Any other byte: discarded, stay in IDLE.
  - CNT_H: capture the high count byte, go to CNT_L.
  - CNT_L: capture the low count byte. Go to LOAD, or to CSUM if N==0. Reset waddr_o to 0, byte index to 0, checksum to 0.
  - LOAD: shift the byte into the word register and XOR it into the checksum. When the last byte of a word is accepted, go to WRITE.
  - WRITE (one cycle):
    - rx_ready_o=0, we_o=1, wdata_o = the assembled word, waddr_o = the current address.
    - Next cycle: we_o=0 and waddr_o increments.
    - Go to CSUM if the words-remaining count reaches 0, else go to LOAD.
  - CSUM: compare the accepted byte with the running checksum; err_o = mismatch. Go to DONE.
  - DONE (one cycle): busy_o=0, cpu_hold_o=0, done_o=1, then go to IDLE.
    - On error, cpu_hold_o still releases; firmware must check err_o.
- Latency: we_o asserts in the cycle after the posedge that accepts the final byte of a word.
  - Minimum spacing between writes is DATA_W/8+1 cycles.
- Address wrap: waddr_o wraps modulo 2^ADDR_W. Writes continue and no error is raised.
- rx_valid_i deasserted mid-frame: the loader waits indefinitely in its current state. There is no timeout.
- MAGIC appearing inside the frame (count, payload or CSUM position) is treated as data, not as a resync.
- Reset mid-frame: everything returns to reset values immediately and asynchronously. Any partial word is discarded and no write occurs.
- rx_data_i and rx_valid_i are ignored while rx_ready_o=0. Upstream must hold the byte until it is accepted.
- The imem write port is sampled on posedge. waddr_o and wdata_o are stable for the whole cycle in which we_o=1.

Test Plan (DATA_W=32, ADDR_W=8):
- Bytes A5,00,02,11,22,33,44,DE,AD,BE,EF,CSUM=0x66 with rx_valid_i always high:
  - writes 0x11223344 to addr 0 and 0xDEADBEEF to addr 1
  - done_o=1, err_o=0, cpu_hold_o high from the MAGIC accept until the DONE cycle
  - rx_ready_o low exactly 2 cycles
- Same frame with CSUM=0x67: both writes occur, done_o=1, err_o=1.
- Garbage bytes 00,FF,5A, then A5,00,00,00: no we_o pulses, done_o=1, err_o=0, garbage ignored.
- Count 0x0101 (257 words), each word equal to its index: the last write goes to addr 0x00 with data 0x00000100 (wrap), done_o=1.
- rx_valid_i toggled randomly 50% over the first frame: identical writes and flags to the first test.
- rst_n pulsed low after 2 payload bytes:
  - all outputs clear immediately and no we_o pulse occurs
  - a new full frame afterward loads correctly from addr 0.
